// File: rtl/clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : clock_div_prog
// Brief    : Runtime-programmable multi-channel clock divider. Each channel
//            divides CLK_IN by its own full-period divisor, producing a
//            near-50% square output and a one-cycle period-start tick.
//            Divisor updates are shadowed and applied at period boundaries.
//            SYNC restarts all running channels in phase.
// Revision : 1.0 - initial release (successor to the fixed 1 MHz -> 1 kHz divider)
// ============================================================================
module clock_div_prog #(
   parameter int NUM_CH      = 2,
   parameter int CNT_WIDTH   = 17,
   parameter int DEFAULT_DIV = 1000
) (
   input  logic                        CLK_IN,
   input  logic                        RESET_N,
   input  logic [NUM_CH-1:0]           EN,
   input  logic [NUM_CH-1:0]           LOAD,
   input  logic [NUM_CH*CNT_WIDTH-1:0] DIV_IN,
   input  logic                        SYNC,
   output logic [NUM_CH-1:0]           CLK_OUT,
   output logic [NUM_CH-1:0]           TICK_OUT,
   output logic [NUM_CH-1:0]           PENDING
);

   localparam logic [0:0]           c_st_idle = 1'b0;
   localparam logic [0:0]           c_st_run  = 1'b1;
   localparam logic [CNT_WIDTH-1:0] c_min     = CNT_WIDTH'(2);
   localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH:0]   c_one_w   = (CNT_WIDTH+1)'(1);
   localparam logic [CNT_WIDTH-1:0] c_default =
      (DEFAULT_DIV < 2) ? c_min : CNT_WIDTH'(DEFAULT_DIV);

   // Divisors below 2 cannot form a high and a low phase, so they run as 2.
   function automatic logic [CNT_WIDTH-1:0] f_clamp(input logic [CNT_WIDTH-1:0] v);
      return (v < c_min) ? c_min : v;
   endfunction

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [0:0]           r_state;
      logic [0:0]           w_state_nxt;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] w_cnt_nxt;
      logic [CNT_WIDTH-1:0] r_dact;
      logic [CNT_WIDTH-1:0] w_dact_nxt;
      logic [CNT_WIDTH-1:0] r_shadow;
      logic [CNT_WIDTH-1:0] w_shadow_nxt;
      logic                 r_pend;
      logic                 w_pend_nxt;
      logic                 r_clk;
      logic                 w_clk_nxt;
      logic                 r_tick;
      logic                 w_tick_nxt;
      logic [CNT_WIDTH:0]   w_half;
      logic [CNT_WIDTH-1:0] w_div_cl;
      logic                 w_boundary;

      assign w_div_cl   = f_clamp(DIV_IN[k*CNT_WIDTH +: CNT_WIDTH]);
      assign w_boundary = (r_cnt == (r_dact - c_one));

      // Next-state for the channel; outputs are derived from the next cnt/D_act
      // so the registered outputs always match the registered counter state.
      always_comb begin
         w_state_nxt  = r_state;
         w_cnt_nxt    = r_cnt;
         w_dact_nxt   = r_dact;
         w_shadow_nxt = r_shadow;
         w_pend_nxt   = r_pend;
         case (r_state)
            c_st_idle: begin
               w_cnt_nxt  = '0;
               w_pend_nxt = 1'b0;
               if (LOAD[k]) begin
                  w_dact_nxt   = w_div_cl;
                  w_shadow_nxt = w_div_cl;
               end
               if (EN[k]) begin
                  w_state_nxt = c_st_run;
               end
            end
            default: begin
               if (!EN[k]) begin
                  w_state_nxt = c_st_idle;
                  w_cnt_nxt   = '0;
                  w_pend_nxt  = 1'b0;
                  if (LOAD[k]) begin
                     w_dact_nxt   = w_div_cl;
                     w_shadow_nxt = w_div_cl;
                  end else if (r_pend) begin
                     w_dact_nxt = r_shadow;
                  end
               end else if (SYNC || w_boundary) begin
                  w_cnt_nxt = '0;
                  if (SYNC && LOAD[k]) begin
                     // Load coinciding with SYNC takes effect immediately.
                     w_dact_nxt   = w_div_cl;
                     w_shadow_nxt = w_div_cl;
                     w_pend_nxt   = 1'b0;
                  end else begin
                     if (r_pend) begin
                        w_dact_nxt = r_shadow;
                     end
                     // A load on a natural boundary waits for the next one.
                     w_pend_nxt = LOAD[k];
                     if (LOAD[k]) begin
                        w_shadow_nxt = w_div_cl;
                     end
                  end
               end else begin
                  w_cnt_nxt = r_cnt + c_one;
                  if (LOAD[k]) begin
                     w_shadow_nxt = w_div_cl;
                     w_pend_nxt   = 1'b1;
                  end
               end
            end
         endcase
         // One extra bit keeps ceil(D/2) exact for the maximum divisor.
         w_half     = ({1'b0, w_dact_nxt} + c_one_w) >> 1;
         w_clk_nxt  = (w_state_nxt == c_st_run) && ({1'b0, w_cnt_nxt} < w_half);
         w_tick_nxt = (w_state_nxt == c_st_run) && (w_cnt_nxt == '0);
      end

      // Channel state registers with asynchronous return to defaults.
      always_ff @(posedge CLK_IN or negedge RESET_N) begin
         if (!RESET_N) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_dact   <= c_default;
            r_shadow <= c_default;
            r_pend   <= 1'b0;
            r_clk    <= 1'b0;
            r_tick   <= 1'b0;
         end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dact   <= w_dact_nxt;
            r_shadow <= w_shadow_nxt;
            r_pend   <= w_pend_nxt;
            r_clk    <= w_clk_nxt;
            r_tick   <= w_tick_nxt;
         end
      end

      assign CLK_OUT[k]  = r_clk;
      assign TICK_OUT[k] = r_tick;
      assign PENDING[k]  = r_pend;
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_div_prog
// Brief    : Bench for clock_div_prog (2 channels, 17-bit, default 1000).
//            Period-timestamp model checked every cycle plus directed
//            period/high-time measurements with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_prog;

   localparam int W = 17;

   logic           CLK_IN = 1'b0;
   logic           RESET_N = 1'b0;
   logic [1:0]     EN = '0;
   logic [1:0]     LOAD = '0;
   logic [2*W-1:0] DIV_IN = '0;
   logic           SYNC = 1'b0;
   logic [1:0]     CLK_OUT;
   logic [1:0]     TICK_OUT;
   logic [1:0]     PENDING;

   int tests = 0;
   int fails = 0;

   clock_div_prog #(.NUM_CH(2), .CNT_WIDTH(W), .DEFAULT_DIV(1000)) u_dut (
      .CLK_IN   (CLK_IN),
      .RESET_N  (RESET_N),
      .EN       (EN),
      .LOAD     (LOAD),
      .DIV_IN   (DIV_IN),
      .SYNC     (SYNC),
      .CLK_OUT  (CLK_OUT),
      .TICK_OUT (TICK_OUT),
      .PENDING  (PENDING)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: each period is a timestamp plus a divisor ----------
   int cyc = 0;
   int m_run[2];
   int m_start[2];
   int m_d[2];
   int m_sh[2];
   int m_pend[2];

   function automatic int clampv(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   initial begin
      forever begin
         @(posedge CLK_IN or negedge RESET_N);
         if (!RESET_N) begin
            for (int k = 0; k < 2; k++) begin
               m_run[k] = 0; m_start[k] = 0; m_d[k] = 1000; m_sh[k] = 1000; m_pend[k] = 0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
               int v;
               v = clampv(int'(DIV_IN[k*W +: W]));
               if (m_run[k] == 0) begin
                  if (LOAD[k]) begin m_d[k] = v; m_sh[k] = v; end
                  m_pend[k] = 0;
                  if (EN[k]) begin m_run[k] = 1; m_start[k] = cyc; end
               end else if (!EN[k]) begin
                  m_run[k] = 0;
                  if (LOAD[k]) m_d[k] = v;
                  else if (m_pend[k] != 0) m_d[k] = m_sh[k];
                  m_pend[k] = 0;
               end else if (SYNC) begin
                  m_start[k] = cyc;
                  if (LOAD[k]) begin m_d[k] = v; m_sh[k] = v; m_pend[k] = 0; end
                  else if (m_pend[k] != 0) begin m_d[k] = m_sh[k]; m_pend[k] = 0; end
               end else if (cyc - m_start[k] == m_d[k]) begin
                  m_start[k] = cyc;
                  if (m_pend[k] != 0) m_d[k] = m_sh[k];
                  m_pend[k] = LOAD[k] ? 1 : 0;
                  if (LOAD[k]) m_sh[k] = v;
               end else if (LOAD[k]) begin
                  m_sh[k] = v; m_pend[k] = 1;
               end
            end
         end
      end
   end

   // Every falling edge: DUT outputs against the model.
   initial begin
      forever begin
         @(negedge CLK_IN);
         for (int k = 0; k < 2; k++) begin
            int age;
            age = cyc - m_start[k];
            chk($sformatf("model clk_out[%0d]", k), 32'(CLK_OUT[k]),
                32'((m_run[k] != 0) && (age < (m_d[k] + 1) / 2)));
            chk($sformatf("model tick_out[%0d]", k), 32'(TICK_OUT[k]),
                32'((m_run[k] != 0) && (age == 0)));
            chk($sformatf("model pending[%0d]", k), 32'(PENDING[k]), 32'(m_pend[k]));
         end
      end
   end

   // ---------------- directed helpers ------------------------------------------
   // Entered on the falling edge of a tick; counts one period of channel ch,
   // optionally pulsing LOAD at cycle offset load_at within it.
   task automatic measure(input int ch, input int load_at, input int val,
                          output int per, output int hi);
      per = 0;
      hi  = 0;
      do begin
         if (CLK_OUT[ch]) hi++;
         LOAD[ch] = (per == load_at);
         if (per == load_at) DIV_IN[ch*W +: W] = val[W-1:0];
         per++;
         @(negedge CLK_IN);
      end while (!TICK_OUT[ch] && per < 2000);
      LOAD[ch] = 1'b0;
   endtask

   task automatic wait_tick(input int ch);
      int n;
      n = 0;
      while (!TICK_OUT[ch] && n < 3000) begin
         @(negedge CLK_IN);
         n++;
      end
      chk($sformatf("wait_tick[%0d]", ch), 32'(TICK_OUT[ch]), 32'd1);
   endtask

   task automatic period_chk(input string name, input int ch, input int load_at,
                             input int val, input int exp_per, input int exp_hi);
      int per;
      int hi;
      measure(ch, load_at, val, per, hi);
      chk({name, " period"}, per, exp_per);
      chk({name, " high"}, hi, exp_hi);
   endtask

   // ---------------- directed sequence -----------------------------------------
   initial begin
      // Reset state
      repeat (3) @(negedge CLK_IN);
      chk("reset clk_out", 32'(CLK_OUT), 32'd0);
      chk("reset tick_out", 32'(TICK_OUT), 32'd0);
      chk("reset pending", 32'(PENDING), 32'd0);
      RESET_N = 1'b1;
      @(negedge CLK_IN);

      // Default divisor 1000, first tick one clock after EN
      EN[0] = 1'b1;
      @(negedge CLK_IN);
      chk("first tick", 32'(TICK_OUT[0]), 32'd1);
      chk("first clk", 32'(CLK_OUT[0]), 32'd1);
      chk("ch1 idle", 32'(TICK_OUT[1]), 32'd0);
      period_chk("d1000 a", 0, -1, 0, 1000, 500);
      period_chk("d1000 b", 0, -1, 0, 1000, 500);

      // D=10 then LOAD 7 at cnt=3
      EN[0] = 1'b0;
      @(negedge CLK_IN);
      LOAD[0] = 1'b1; DIV_IN[0 +: W] = W'(10); EN[0] = 1'b1;
      @(negedge CLK_IN);
      LOAD[0] = 1'b0;
      chk("d10 start tick", 32'(TICK_OUT[0]), 32'd1);
      period_chk("d10 with load7", 0, 3, 7, 10, 5);
      chk("pending cleared at boundary", 32'(PENDING[0]), 32'd0);
      period_chk("d7", 0, -1, 0, 7, 4);

      // Clamp of 0 and 1, then maximum divisor
      period_chk("d7 with load0", 0, 1, 0, 7, 4);
      period_chk("clamp0", 0, -1, 0, 2, 1);
      period_chk("clamp0 with load1", 0, 0, 1, 2, 1);
      period_chk("clamp1", 0, -1, 0, 2, 1);
      period_chk("d2 with loadmax", 0, 0, 131071, 2, 1);
      chk("max pending", 32'(PENDING[0]), 32'd0);
      chk("max clk start", 32'(CLK_OUT[0]), 32'd1);
      repeat (300) @(negedge CLK_IN);
      chk("max clk still high", 32'(CLK_OUT[0]), 32'd1);

      // Two channels out of phase, then SYNC
      EN = 2'b00;
      @(negedge CLK_IN);
      LOAD = 2'b11; DIV_IN = {W'(9), W'(6)};
      @(negedge CLK_IN);
      LOAD = 2'b00; EN = 2'b01;
      repeat (2) @(negedge CLK_IN);
      EN = 2'b11;
      repeat (20) @(negedge CLK_IN);
      SYNC = 1'b1;
      @(negedge CLK_IN);
      SYNC = 1'b0;
      chk("sync ticks", 32'(TICK_OUT), 32'd3);
      chk("sync clks", 32'(CLK_OUT), 32'd3);
      repeat (5) @(negedge CLK_IN);
      SYNC = 1'b1; LOAD[1] = 1'b1; DIV_IN[W +: W] = W'(4);
      @(negedge CLK_IN);
      SYNC = 1'b0; LOAD[1] = 1'b0;
      chk("sync+load tick", 32'(TICK_OUT[1]), 32'd1);
      chk("sync+load pending", 32'(PENDING[1]), 32'd0);
      period_chk("ch1 d4", 1, -1, 0, 4, 2);

      // Drop EN[0] during high phase, then re-enable
      wait_tick(0);
      @(negedge CLK_IN);
      EN[0] = 1'b0;
      @(negedge CLK_IN);
      chk("en drop clk", 32'(CLK_OUT[0]), 32'd0);
      EN[0] = 1'b1;
      @(negedge CLK_IN);
      chk("re-enable tick", 32'(TICK_OUT[0]), 32'd1);
      period_chk("ch0 d6", 0, -1, 0, 6, 3);

      // Asynchronous reset between edges
      @(negedge CLK_IN);
      #2 RESET_N = 1'b0;
      #1;
      chk("async clk_out", 32'(CLK_OUT), 32'd0);
      chk("async tick_out", 32'(TICK_OUT), 32'd0);
      chk("async pending", 32'(PENDING), 32'd0);
      @(negedge CLK_IN);
      RESET_N = 1'b1;
      @(negedge CLK_IN);
      wait_tick(0);
      period_chk("post reset d1000", 0, -1, 0, 1000, 500);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
